nmalloc_pool: RTL and testbench

Parametrised fixed-block pool allocator servicing both `malloc` and `free` requests from a single-issue start/finish handshake, as used by the generated datapath for `nmalloc` calls. It replaces the single-table, allocate-only scheme with a configurable pool: block count, block size, base address and address width are set at elaboration. The block tracks ownership of every block and rejects invalid or double frees. It sits between the calling datapath FSM and the memory controller address space and gives up its turn whenever the memory controller stalls.

---
 rtl/nmalloc_pool.sv | 195 +++++++++++++++++++
 tb/tb_nmalloc_pool.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/nmalloc_pool.sv
// nmalloc_pool: fixed-block pool allocator with malloc/free over a
// start/finish handshake. A LIFO free stack hands out block indices, an
// ownership bitmap rejects frees of blocks that are not currently allocated,
// and the whole block freezes while the memory controller stalls.
module nmalloc_pool #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       NUM_BLOCKS  = 16,
  parameter int unsigned       BLOCK_BYTES = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h0000_1000)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              memory_controller_waitrequest,
  input  logic                              start,
  input  logic                              op,
  input  logic [31:0]                       arg_bytes,
  input  logic [ADDR_W-1:0]                 arg_ptr,
  output logic                              ready,
  output logic                              finish,
  output logic [ADDR_W-1:0]                 return_val,
  output logic                              error,
  output logic [$clog2(NUM_BLOCKS+1)-1:0]   free_count
);

  localparam int unsigned IDX_W  = $clog2(NUM_BLOCKS);
  localparam int unsigned CNT_W  = $clog2(NUM_BLOCKS + 1);
  localparam int unsigned LOG_BB = $clog2(BLOCK_BYTES);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Byte address of block k; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] blk_addr(input logic [IDX_W-1:0] k);
    blk_addr = BASE_ADDR + (ADDR_W'(k) << LOG_BB);
  endfunction

  state_t                  state_r, state_s;
  logic [CNT_W-1:0]        sp_r, sp_s;
  logic [NUM_BLOCKS-1:0]   alloc_map_r, alloc_map_s;
  logic [IDX_W-1:0]        stk_r [NUM_BLOCKS];
  logic                    op_r, op_s;
  logic [31:0]             bytes_r, bytes_s;
  logic [ADDR_W-1:0]       ptr_r, ptr_s;
  logic [ADDR_W-1:0]       ret_r, ret_s;
  logic                    err_r, err_s;
  logic                    ready_r, ready_s;
  logic                    finish_r, finish_s;

  logic                    stk_we_s;
  logic [IDX_W-1:0]        stk_wa_s;
  logic [IDX_W-1:0]        stk_wd_s;

  logic [CNT_W-1:0]        sp_dec_s;
  logic [IDX_W-1:0]        top_idx_s;
  logic [ADDR_W-1:0]       off_s;
  logic [ADDR_W-1:0]       blk_s;
  logic [IDX_W-1:0]        free_idx_s;
  logic                    ptr_ok_s;
  logic                    size_bad_s;

  // Stack top and free-pointer decode feeding the EXEC step.
  always_comb begin
    sp_dec_s   = sp_r - CNT_W'(1);
    top_idx_s  = stk_r[sp_dec_s[IDX_W-1:0]];
    off_s      = ptr_r - BASE_ADDR;
    blk_s      = off_s >> LOG_BB;
    free_idx_s = blk_s[IDX_W-1:0];
    size_bad_s = (bytes_r == 32'd0) || (bytes_r > 32'(BLOCK_BYTES));
    ptr_ok_s   = (ptr_r >= BASE_ADDR) &&
                 (off_s[LOG_BB-1:0] == {LOG_BB{1'b0}}) &&
                 (blk_s < ADDR_W'(NUM_BLOCKS)) &&
                 alloc_map_r[free_idx_s];
  end

  // Next-state and next-output logic; a stall leaves everything unchanged.
  always_comb begin
    state_s     = state_r;
    sp_s        = sp_r;
    alloc_map_s = alloc_map_r;
    op_s        = op_r;
    bytes_s     = bytes_r;
    ptr_s       = ptr_r;
    ret_s       = ret_r;
    err_s       = err_r;
    stk_we_s    = 1'b0;
    stk_wa_s    = sp_r[IDX_W-1:0];
    stk_wd_s    = {IDX_W{1'b0}};
    if (memory_controller_waitrequest) begin
      state_s = state_r;
    end else begin
      case (state_r)
        ST_INIT: begin
          // Fill so that the first pop yields block 0.
          stk_we_s = 1'b1;
          stk_wd_s = IDX_W'(NUM_BLOCKS - 1) - sp_r[IDX_W-1:0];
          sp_s     = sp_r + CNT_W'(1);
          if (sp_r == CNT_W'(NUM_BLOCKS - 1)) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_INIT;
          end
        end
        ST_IDLE: begin
          if (start) begin
            op_s    = op;
            bytes_s = arg_bytes;
            ptr_s   = arg_ptr;
            state_s = ST_EXEC;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_EXEC: begin
          state_s = ST_DONE;
          if (!op_r) begin
            if (size_bad_s || (sp_r == {CNT_W{1'b0}})) begin
              ret_s = {ADDR_W{1'b0}};
              err_s = 1'b1;
            end else begin
              sp_s                   = sp_dec_s;
              alloc_map_s[top_idx_s] = 1'b1;
              ret_s                  = blk_addr(top_idx_s);
              err_s                  = 1'b0;
            end
          end else begin
            ret_s = {ADDR_W{1'b0}};
            if (ptr_ok_s) begin
              // A valid free implies sp < NUM_BLOCKS, so the push slot exists.
              stk_we_s                = 1'b1;
              stk_wd_s                = free_idx_s;
              sp_s                    = sp_r + CNT_W'(1);
              alloc_map_s[free_idx_s] = 1'b0;
              err_s                   = 1'b0;
            end else begin
              err_s = 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_INIT;
        end
      endcase
    end
    ready_s  = (state_s == ST_IDLE);
    finish_s = (state_s == ST_DONE);
  end

  // State, pointer, bitmap, request latches and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_INIT;
      sp_r        <= {CNT_W{1'b0}};
      alloc_map_r <= {NUM_BLOCKS{1'b0}};
      op_r        <= 1'b0;
      bytes_r     <= 32'd0;
      ptr_r       <= {ADDR_W{1'b0}};
      ret_r       <= {ADDR_W{1'b0}};
      err_r       <= 1'b0;
      ready_r     <= 1'b0;
      finish_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      sp_r        <= sp_s;
      alloc_map_r <= alloc_map_s;
      op_r        <= op_s;
      bytes_r     <= bytes_s;
      ptr_r       <= ptr_s;
      ret_r       <= ret_s;
      err_r       <= err_s;
      ready_r     <= ready_s;
      finish_r    <= finish_s;
    end
  end

  // Free-stack storage; contents are only meaningful below sp, so no reset.
  always_ff @(posedge clk) begin
    if (stk_we_s) begin
      stk_r[stk_wa_s] <= stk_wd_s;
    end
  end

  assign ready      = ready_r;
  assign finish     = finish_r;
  assign return_val = ret_r;
  assign error      = err_r;
  assign free_count = sp_r;

endmodule

// File: tb/tb_nmalloc_pool.sv
// Scoreboard bench for nmalloc_pool with default parameters: requests push
// their hand-computed result and finish cycle; a negedge monitor pops and
// compares on every unstalled finish.
module tb_nmalloc_pool;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] arg_bytes = 32'd0;
  logic [31:0] arg_ptr = 32'd0;
  logic        ready;
  logic        finish;
  logic [31:0] return_val;
  logic        error;
  logic [4:0]  free_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] ret;
    logic        err;
    logic [4:0]  fc;
    int          fin_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  nmalloc_pool dut (
    .clk                           (clk),
    .reset                         (reset),
    .memory_controller_waitrequest (wr),
    .start                         (start),
    .op                            (op),
    .arg_bytes                     (arg_bytes),
    .arg_ptr                       (arg_ptr),
    .ready                         (ready),
    .finish                        (finish),
    .return_val                    (return_val),
    .error                         (error),
    .free_count                    (free_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one comparison set per finish that is not held by a stall.
  always @(negedge clk) begin
    if (!reset && finish && !wr) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_finish: actual finish=1 at cycle %0d required no finish", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("return_val", 64'(return_val), 64'(mon_e.ret));
        check("error", 64'(error), 64'(mon_e.err));
        check("free_count", 64'(free_count), 64'(mon_e.fc));
        check("finish_cycle", 64'(cyc), 64'(mon_e.fin_cyc));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(ready && sb.size() == 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: actual ready=%0b pending=%0d required ready=1 pending=0",
               ready, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_req(input logic o, input logic [31:0] bytes, input logic [31:0] ptr,
                        input logic [31:0] eret, input logic eerr, input logic [4:0] efc,
                        input int stall);
    exp_t e;
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1;
    op = o;
    arg_bytes = bytes;
    arg_ptr = ptr;
    e.ret = eret;
    e.err = eerr;
    e.fc = efc;
    e.fin_cyc = cyc + 2 + stall;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    if (stall > 0) begin
      wr = 1'b1;
      for (int i = 0; i < stall; i++) begin
        start = (i == 1 || i == 3) ? 1'b1 : 1'b0;
        @(posedge clk); #1;
      end
      start = 1'b0;
      wr = 1'b0;
    end
  endtask

  task automatic release_and_init();
    int n;
    @(posedge clk); #1;
    reset = 1'b0;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ready) break;
    end
    check("init_cycles", 64'(n), 64'd16);
    check("free_count_after_init", 64'(free_count), 64'd16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running required finished");
    $fatal(1);
  end

  initial begin
    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_finish", 64'(finish), 64'd0);
    check("rst_return_val", 64'(return_val), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_free_count", 64'(free_count), 64'd0);
    release_and_init();

    // First allocations and LIFO reuse.
    do_req(1'b0, 32'd64, 32'd0, 32'h1000, 1'b0, 5'd15, 0);
    do_req(1'b0, 32'd1,  32'd0, 32'h1040, 1'b0, 5'd14, 0);
    do_req(1'b1, 32'd0,  32'h1040, 32'h0, 1'b0, 5'd15, 0);
    do_req(1'b0, 32'd4,  32'd0, 32'h1040, 1'b0, 5'd14, 0);

    // Double free, misaligned, out of range, below base, NULL.
    do_req(1'b1, 32'd0, 32'h1040, 32'h0, 1'b0, 5'd15, 0);
    do_req(1'b1, 32'd0, 32'h1040, 32'h0, 1'b1, 5'd15, 0);
    do_req(1'b1, 32'd0, 32'h1044, 32'h0, 1'b1, 5'd15, 0);
    do_req(1'b1, 32'd0, 32'h1400, 32'h0, 1'b1, 5'd15, 0);
    do_req(1'b1, 32'd0, 32'h0FC0, 32'h0, 1'b1, 5'd15, 0);
    do_req(1'b1, 32'd0, 32'h0000, 32'h0, 1'b1, 5'd15, 0);

    // Bad sizes while blocks are free.
    do_req(1'b0, 32'd0,  32'd0, 32'h0, 1'b1, 5'd15, 0);
    do_req(1'b0, 32'd65, 32'd0, 32'h0, 1'b1, 5'd15, 0);

    // Return block 0, then exhaust the pool in address order.
    do_req(1'b1, 32'd0, 32'h1000, 32'h0, 1'b0, 5'd16, 0);
    for (int i = 0; i < 16; i++) begin
      do_req(1'b0, 32'd64, 32'd0, 32'h1000 + 32'(i) * 32'd64, 1'b0, 5'(15 - i), 0);
    end
    do_req(1'b0, 32'd64, 32'd0, 32'h0, 1'b1, 5'd0, 0);

    // Stall in EXEC for 5 cycles, with ignored start pulses.
    do_req(1'b1, 32'd0,  32'h1140, 32'h0, 1'b0, 5'd1, 0);
    do_req(1'b0, 32'd32, 32'd0, 32'h1140, 1'b0, 5'd0, 5);
    do_req(1'b0, 32'd8,  32'd0, 32'h0, 1'b1, 5'd0, 0);

    // Reset in the middle of an alloc with 3 blocks allocated.
    wait_idle();
    @(posedge clk); #1;
    reset = 1'b1;
    release_and_init();
    do_req(1'b0, 32'd16, 32'd0, 32'h1000, 1'b0, 5'd15, 0);
    do_req(1'b0, 32'd16, 32'd0, 32'h1040, 1'b0, 5'd14, 0);
    do_req(1'b0, 32'd16, 32'd0, 32'h1080, 1'b0, 5'd13, 0);
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1;
    op = 1'b0;
    arg_bytes = 32'd16;
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("midreset_finish", 64'(finish), 64'd0);
    check("midreset_free_count", 64'(free_count), 64'd0);
    release_and_init();
    do_req(1'b0, 32'd64, 32'd0, 32'h1000, 1'b0, 5'd15, 0);
    wait_idle();
    repeat (4) @(negedge clk);
    check("pending_at_end", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
